mem_bus_arbiter: RTL and testbench

Two-master, one-slave memory bus arbiter sitting directly downstream of the instruction cache controller and the writeback data cache controller. It grants the single external memory port to one cache at a time and holds the grant for the whole request, including a multi-beat writeback followed by a refill. It forwards address, write data and direction to memory, and returns per-beat BusReady and read data to the owning cache. A watchdog flags a hung memory.

---
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction cache F, data cache M) to one-slave memory bus arbiter.
// Round-robin on ties, grant held for the whole request, sticky watchdog on a hung memory.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HRequestF,
    input  logic [31:0] HAddrF,
    output logic        BusReadyF,
    input  logic        HRequestM,
    input  logic        HWriteM,
    input  logic [31:0] HAddrM,
    input  logic [31:0] HWDataM,
    output logic        BusReadyM,
    output logic [31:0] HRData,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic        GrantM,
    output logic        BusError
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWNF = 2'd1,
        OWNM = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            last_m_r;
    logic            last_m_s;
    logic [CW-1:0]   wait_cnt_r;
    logic [CW-1:0]   wait_cnt_s;
    logic            bus_error_r;

    // State, round-robin history and watchdog registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            last_m_r    <= 1'b0;
            wait_cnt_r  <= '0;
            bus_error_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_m_r   <= last_m_s;
            wait_cnt_r <= wait_cnt_s;
            if (wait_cnt_r == TMAX) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end

    // Next-state arbitration; the owner keeps the bus until its request drops
    always_comb begin
        state_s  = state_r;
        last_m_s = last_m_r;
        case (state_r)
            IDLE: begin
                if (HRequestF && HRequestM) begin
                    // tie goes to whichever master did not own the bus last
                    if (last_m_r) begin
                        state_s  = OWNF;
                        last_m_s = 1'b0;
                    end else begin
                        state_s  = OWNM;
                        last_m_s = 1'b1;
                    end
                end else if (HRequestF) begin
                    state_s  = OWNF;
                    last_m_s = 1'b0;
                end else if (HRequestM) begin
                    state_s  = OWNM;
                    last_m_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWNF: begin
                if (HRequestF) begin
                    state_s = OWNF;
                end else begin
                    state_s = IDLE;
                end
            end
            OWNM: begin
                if (HRequestM) begin
                    state_s = OWNM;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Memory-side muxing and per-beat ready steering from the current owner
    always_comb begin
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        MemAddr   = 32'd0;
        MemWData  = 32'd0;
        BusReadyF = 1'b0;
        BusReadyM = 1'b0;
        GrantM    = 1'b0;
        case (state_r)
            OWNF: begin
                MemReq    = HRequestF;
                MemAddr   = HAddrF;
                BusReadyF = HRequestF & MemReady;
            end
            OWNM: begin
                MemReq    = HRequestM;
                MemWrite  = HWriteM;
                MemAddr   = HAddrM;
                MemWData  = HWDataM;
                BusReadyM = HRequestM & MemReady;
                GrantM    = 1'b1;
            end
            default: begin
                MemReq = 1'b0;
            end
        endcase
    end

    // Watchdog counter: consecutive unanswered beat cycles, saturating
    always_comb begin
        wait_cnt_s = '0;
        if (MemReq && !MemReady) begin
            if (wait_cnt_r == TMAX) begin
                wait_cnt_s = wait_cnt_r;
            end else begin
                wait_cnt_s = wait_cnt_r + CW'(1);
            end
        end else begin
            wait_cnt_s = '0;
        end
    end

    assign HRData   = MemRData;
    assign BusError = bus_error_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=4): reset, refill, writeback,
// round-robin handover, wait states and the sticky watchdog.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        HRequestF;
    logic [31:0] HAddrF;
    logic        BusReadyF;
    logic        HRequestM;
    logic        HWriteM;
    logic [31:0] HAddrM;
    logic [31:0] HWDataM;
    logic        BusReadyM;
    logic [31:0] HRData;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;
    logic        GrantM;
    logic        BusError;

    int total = 0;
    int bad   = 0;
    int pulses;

    mem_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .HRequestF(HRequestF), .HAddrF(HAddrF), .BusReadyF(BusReadyF),
        .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM),
        .HWDataM(HWDataM), .BusReadyM(BusReadyM), .HRData(HRData),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemReady(MemReady), .MemRData(MemRData),
        .GrantM(GrantM), .BusError(BusError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; HRequestF = 1'b1; HRequestM = 1'b1; HWriteM = 1'b0;
        HAddrF = 32'h100; HAddrM = 32'h200; HWDataM = 32'h0;
        MemReady = 1'b0; MemRData = 32'h5A;

        // reset held with both requests high
        for (int i = 0; i < 3; i++) begin
            tick(); #4;
            chk("rst_memreq", {31'd0, MemReq}, 32'd0);
            chk("rst_grantm", {31'd0, GrantM}, 32'd0);
            chk("rst_buserr", {31'd0, BusError}, 32'd0);
        end
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_hrdata", HRData, 32'h5A);
        reset = 1'b1; #4;
        chk("rel_idle_memreq", {31'd0, MemReq}, 32'd0);

        // first tie goes to M; single four-beat refill
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            HRequestF = 1'b0; MemReady = 1'b1;
            MemRData = 32'hA0 + 32'(i); HAddrM = 32'h200 + 32'(i);
            #4;
            chk("ref_grantm", {31'd0, GrantM}, 32'd1);
            chk("ref_busreadym", {31'd0, BusReadyM}, 32'd1);
            chk("ref_busreadyf", {31'd0, BusReadyF}, 32'd0);
            chk("ref_hrdata", HRData, 32'hA0 + 32'(i));
            chk("ref_memaddr", MemAddr, 32'h200 + 32'(i));
            if (BusReadyM) pulses++;
        end
        chk("ref_pulses", 32'(pulses), 32'd4);
        tick(); HRequestM = 1'b0; #4;
        chk("ref_drop_memreq", {31'd0, MemReq}, 32'd0);
        chk("ref_drop_busreadym", {31'd0, BusReadyM}, 32'd0);
        tick(); #4;
        chk("ref_idle_grantm", {31'd0, GrantM}, 32'd0);
        chk("ref_idle_memaddr", MemAddr, 32'd0);

        // writeback (4 beats) then refill (4 beats) in one tenure
        HRequestM = 1'b1; HWriteM = 1'b1; #1;
        chk("wb_dead_memreq", {31'd0, MemReq}, 32'd0);
        chk("wb_dead_memwrite", {31'd0, MemWrite}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            HWriteM = (i < 4); HWDataM = 32'h11 + 32'(i); HAddrM = 32'h300 + 32'(i);
            #4;
            chk("wb_memwrite", {31'd0, MemWrite}, (i < 4) ? 32'd1 : 32'd0);
            chk("wb_memwdata", MemWData, 32'h11 + 32'(i));
            chk("wb_memaddr", MemAddr, 32'h300 + 32'(i));
            if (BusReadyM) pulses++;
        end
        chk("wb_pulses", 32'(pulses), 32'd8);
        tick(); HRequestM = 1'b0; HWriteM = 1'b0; #4;
        chk("wb_drop_memreq", {31'd0, MemReq}, 32'd0);
        tick(); #4;

        // tie with LastOwner=M goes to F; M waits until F drops
        HRequestF = 1'b1; HRequestM = 1'b1; HAddrF = 32'h400; HAddrM = 32'h500;
        HWDataM = 32'hDEAD;
        for (int j = 0; j < 3; j++) begin
            tick(); MemRData = 32'hB0 + 32'(j); #4;
            chk("rr_f_grantm", {31'd0, GrantM}, 32'd0);
            chk("rr_f_memaddr", MemAddr, 32'h400);
            chk("rr_f_memwdata", MemWData, 32'd0);
            chk("rr_f_busreadyf", {31'd0, BusReadyF}, 32'd1);
            chk("rr_f_busreadym", {31'd0, BusReadyM}, 32'd0);
        end
        tick(); HRequestF = 1'b0; #4;
        chk("rr_fdrop_memreq", {31'd0, MemReq}, 32'd0);
        chk("rr_fdrop_busreadyf", {31'd0, BusReadyF}, 32'd0);
        tick(); #4;
        chk("rr_idle_memreq", {31'd0, MemReq}, 32'd0);
        chk("rr_idle_grantm", {31'd0, GrantM}, 32'd0);
        tick(); #4;
        chk("rr_m_grantm", {31'd0, GrantM}, 32'd1);
        chk("rr_m_memaddr", MemAddr, 32'h500);
        HRequestF = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick(); #4;
            chk("rr_nopreempt_grantm", {31'd0, GrantM}, 32'd1);
            chk("rr_nopreempt_busreadyf", {31'd0, BusReadyF}, 32'd0);
        end
        tick(); HRequestM = 1'b0; #4;
        chk("rr_mdrop_memreq", {31'd0, MemReq}, 32'd0);
        tick(); #4;
        chk("rr_idle2_memreq", {31'd0, MemReq}, 32'd0);
        tick(); #4;
        chk("rr_f2_grantm", {31'd0, GrantM}, 32'd0);
        chk("rr_f2_memaddr", MemAddr, 32'h400);
        chk("rr_f2_memreq", {31'd0, MemReq}, 32'd1);
        tick(); HRequestF = 1'b0; #4;
        tick(); HRequestF = 1'b1; HRequestM = 1'b1; #4;
        chk("rr_idle3_memreq", {31'd0, MemReq}, 32'd0);
        tick(); HRequestF = 1'b0; #4;
        chk("rr_tie2_grantm", {31'd0, GrantM}, 32'd1);

        // wait states: three unready cycles per beat
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 3; w++) begin
                tick(); MemReady = 1'b0; HAddrM = 32'h600 + 32'(b); #4;
                chk("ws_wait_busreadym", {31'd0, BusReadyM}, 32'd0);
                chk("ws_wait_memaddr", MemAddr, 32'h600 + 32'(b));
            end
            tick(); MemReady = 1'b1; MemRData = 32'hC0 + 32'(b); #4;
            chk("ws_beat_busreadym", {31'd0, BusReadyM}, 32'd1);
            chk("ws_beat_hrdata", HRData, 32'hC0 + 32'(b));
        end
        chk("ws_buserr", {31'd0, BusError}, 32'd0);

        // watchdog: memory stops answering
        for (int w = 1; w <= 7; w++) begin
            tick(); MemReady = 1'b0; #4;
            if (w == 3) chk("wd_early_buserr", {31'd0, BusError}, 32'd0);
            if (w == 7) chk("wd_set_buserr", {31'd0, BusError}, 32'd1);
        end
        tick(); MemReady = 1'b1; #4;
        chk("wd_sticky_buserr", {31'd0, BusError}, 32'd1);
        chk("wd_resume_busreadym", {31'd0, BusReadyM}, 32'd1);
        tick(); HRequestM = 1'b0; #4;
        tick(); #4;
        chk("wd_idle_buserr", {31'd0, BusError}, 32'd1);
        reset = 1'b0;
        tick(); #4;
        chk("wd_reset_buserr", {31'd0, BusError}, 32'd0);
        reset = 1'b1;

        // request pulsed inside IDLE without reaching an edge
        tick(); HRequestF = 1'b1; #2; HRequestF = 1'b0; #2;
        tick(); #4;
        chk("glitch_memreq", {31'd0, MemReq}, 32'd0);
        chk("glitch_memaddr", MemAddr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
